crosswalk_array: RTL



---
 rtl/crosswalk_array.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/crosswalk_array.sv
// crosswalk_array
//   NUM_XW independent pedestrian crosswalk heads. Each channel watches its
//   own traffic-phase lights, latches button requests and runs a
//   RED -> WALK -> FLASH cycle timed in prescaled ticks. An illegal light
//   combination forces the channel into ERROR (flashing stop, xw_error=1).
//
// Parameters
//   NUM_XW     number of channels (>=1)
//   TICK_DIV   clk cycles per timing tick (>=2)
//   WALK_TIME  ticks of walk lamp (>=1)
//   BLINK_TIME ticks of flashing stop after walk (>=1)
//
// Ports (one bit per channel unless noted)
//   clk, reset        clock, synchronous active-high reset
//   red/ylw/grn_trffc_light  traffic phase lights, synchronous to clk
//   cross_button      raw asynchronous pedestrian buttons
//   walk_light        walk lamp
//   stop_light        stop (red hand) lamp
//   cross_rqst        pending request to the phase sequencer
//   xw_error          illegal traffic-light combination seen
//   xw_state_o        debug: 2-bit state per channel, slice [2*i +: 2]
//   walk_count        (only with COUNTDOWN_EN) remaining timer per channel,
//                     slice [i*CW +: CW]; 0 in RED/ERROR
//
// Optional feature macro: COUNTDOWN_EN
//
// Handshake: none; all interfaces are level signals sampled every clk edge.
module crosswalk_array #(
  parameter int NUM_XW     = 2,
  parameter int TICK_DIV   = 100000000,
  parameter int WALK_TIME  = 10,
  parameter int BLINK_TIME = 6,
  localparam int CW = $clog2(((WALK_TIME > BLINK_TIME) ? WALK_TIME : BLINK_TIME) + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_XW-1:0]     red_trffc_light,
  input  logic [NUM_XW-1:0]     ylw_trffc_light,
  input  logic [NUM_XW-1:0]     grn_trffc_light,
  input  logic [NUM_XW-1:0]     cross_button,
  output logic [NUM_XW-1:0]     walk_light,
  output logic [NUM_XW-1:0]     stop_light,
  output logic [NUM_XW-1:0]     cross_rqst,
  output logic [NUM_XW-1:0]     xw_error,
  output logic [2*NUM_XW-1:0]   xw_state_o
`ifdef COUNTDOWN_EN
  ,
  output logic [NUM_XW*CW-1:0]  walk_count
`endif
);

  typedef enum logic [1:0] {
    ST_RED   = 2'd0,
    ST_WALK  = 2'd1,
    ST_FLASH = 2'd2,
    ST_ERROR = 2'd3
  } xw_state_e;

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [CW-1:0] WALK_LOAD  = CW'(WALK_TIME);
  localparam logic [CW-1:0] BLINK_LOAD = CW'(BLINK_TIME);
  localparam logic [CW-1:0] T_ONE      = CW'(1);

  for (genvar g = 0; g < NUM_XW; g++) begin : g_ch
    xw_state_e     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          phase_q, phase_d;
    logic          rqst_q, rqst_d;
    logic          sync1_q, sync2_q, prev_q;
    logic          r, y, gr, legal, tick, rise, entry;

    assign r  = red_trffc_light[g];
    assign y  = ylw_trffc_light[g];
    assign gr = grn_trffc_light[g];

    // Exactly one traffic lamp lit is the only legal combination.
    assign legal = (r & ~y & ~gr) | (~r & y & ~gr) | (~r & ~y & gr);
    assign tick  = (presc_q == PRESC_MAX);
    // Edge on the synchronised button: first high sample at edge k shows up
    // here before edge k+2, so the request flop sets on edge k+2 (3rd edge).
    assign rise  = sync2_q & ~prev_q;

    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      phase_d = phase_q;
      rqst_d  = rqst_q;
      presc_d = presc_q;
      entry   = 1'b0;

      if (tick) begin
        phase_d = ~phase_q;
        if ((state_q == ST_WALK || state_q == ST_FLASH) && timer_q != '0) begin
          timer_d = timer_q - T_ONE;
        end
      end

      case (state_q)
        ST_RED: begin
          if (gr && rqst_q) begin
            state_d = ST_WALK;
            timer_d = WALK_LOAD;
          end
        end
        ST_WALK: begin
          // red is checked first so it wins over a coinciding expiry
          if (r) begin
            state_d = ST_RED;
            timer_d = '0;
          end else if (y || (tick && timer_q == T_ONE)) begin
            state_d = ST_FLASH;
            timer_d = BLINK_LOAD;
            phase_d = 1'b1;
          end
        end
        ST_FLASH: begin
          if (r || (tick && timer_q == T_ONE)) begin
            state_d = ST_RED;
            timer_d = '0;
          end
        end
        ST_ERROR: begin
          if (r) begin
            state_d = ST_RED;
            timer_d = '0;
          end
        end
        default: begin
          state_d = ST_RED;
        end
      endcase

      // Illegal lights override every other transition.
      if (!legal) begin
        state_d = ST_ERROR;
        timer_d = '0;
        if (state_q != ST_ERROR) begin
          phase_d = 1'b1;
        end
      end

      entry = (state_d != state_q);

      // Prescaler restarts on every state entry so state durations are
      // exact multiples of TICK_DIV.
      if (entry || tick) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PRESC_ONE;
      end

      if (rise && state_q != ST_WALK) begin
        rqst_d = 1'b1;
      end
      if (entry && state_d == ST_WALK) begin
        rqst_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_RED;
        presc_q <= '0;
        timer_q <= '0;
        phase_q <= 1'b0;
        rqst_q  <= 1'b0;
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        prev_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        presc_q <= presc_d;
        timer_q <= timer_d;
        phase_q <= phase_d;
        rqst_q  <= rqst_d;
        sync1_q <= cross_button[g];
        sync2_q <= sync1_q;
        prev_q  <= sync2_q;
      end
    end

    // Outputs are straight decodes of flops, so they move on the state edge.
    assign walk_light[g]        = (state_q == ST_WALK);
    assign stop_light[g]        = (state_q == ST_RED) |
                                  (((state_q == ST_FLASH) | (state_q == ST_ERROR)) & phase_q);
    assign cross_rqst[g]        = rqst_q;
    assign xw_error[g]          = (state_q == ST_ERROR);
    assign xw_state_o[2*g +: 2] = state_q;

`ifdef COUNTDOWN_EN
    assign walk_count[g*CW +: CW] =
      (state_q == ST_WALK || state_q == ST_FLASH) ? timer_q : '0;
`endif
  end

endmodule
